// File: rtl/pc_fetch_pkg.sv
// Shared fetch-stage definitions: bus widths, reset polarity, NOP encoding,
// PC increment, default queue depth and the queue entry layout.
package pc_fetch_pkg;

  localparam int unsigned InstAddrBus = 32;
  localparam int unsigned InstBus     = 32;
  localparam logic        RstEnable   = 1'b1;

  localparam logic [InstBus-1:0]     INST_NOP   = 32'h0000_0013;
  localparam logic [InstAddrBus-1:0] PC_INC     = 32'd4;
  localparam int unsigned            QDEPTH_DEF = 2;

  typedef logic [InstAddrBus-1:0] addr_t;
  typedef logic [InstBus-1:0]     inst_t;

  typedef struct packed {
    addr_t pc;
    inst_t inst;
  } fetch_entry_t;

endpackage

// File: rtl/pc_fetch_if.sv
// Instruction-memory request/response bus between the fetch stage (master)
// and instruction memory (slave).
interface pc_fetch_if;
  import pc_fetch_pkg::*;

  logic  imem_req_o;
  addr_t imem_addr_o;
  logic  imem_gnt_i;
  logic  imem_rvalid_i;
  inst_t imem_rdata_i;

  modport master (
    output imem_req_o, imem_addr_o,
    input  imem_gnt_i, imem_rvalid_i, imem_rdata_i
  );

  modport slave (
    input  imem_req_o, imem_addr_o,
    output imem_gnt_i, imem_rvalid_i, imem_rdata_i
  );
endinterface

// File: rtl/pc_fetch_fifo.sv
// fetch_fifo: parameterised synchronous FIFO with flush and occupancy count,
// used for both the instruction queue and the request-PC tag FIFO.
module fetch_fifo
  import pc_fetch_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 2
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           flush,
  input  logic                           push,
  input  logic [WIDTH-1:0]               din,
  input  logic                           pop,
  output logic [WIDTH-1:0]               dout,
  output logic                           full,
  output logic                           empty,
  output logic [$clog2(DEPTH+1)-1:0]     count
);
  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH-1)) ? '0 : p + 1'b1;
  endfunction

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  // A push into a full FIFO is legal only when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst == RstEnable) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= next_ptr(wr_ptr);
      if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (do_pop && !do_push) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= din;
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(push && !flush && full && !do_pop));

endmodule

// File: rtl/pc_fetch.sv
// Instruction fetch stage: issues in-order memory requests, tags them with
// their PCs, queues returned words for if_id and handles redirects.
// Define FETCH_BYPASS_EN to forward a response straight to the outputs when
// the queue is empty.
module pc_fetch
  import pc_fetch_pkg::*;
#(
  parameter addr_t       RESET_PC = 32'h0000_0000,
  parameter int unsigned QDEPTH   = QDEPTH_DEF
) (
  input  logic       clk_i,
  input  logic       rst_i,
  pc_fetch_if.master imem,
  input  logic       jump_flag_i,
  input  addr_t      jump_addr_i,
  output logic       inst_valid_o,
  output inst_t      inst_o,
  output addr_t      inst_addr_o,
  input  logic       id_ready_i
);
  localparam int unsigned CW = $clog2(QDEPTH+1);
  localparam int unsigned DW = 8;
  localparam logic [CW:0] QLIM = QDEPTH[CW:0];

  addr_t        pc;
  logic [DW-1:0] drop_cnt;
  logic         grant;
  logic         resp_keep;
  logic         byp;
  logic         q_push, q_pop;
  fetch_entry_t q_din, q_dout;
  logic         q_full, q_empty;
  logic [CW-1:0] q_count;
  addr_t        tag_dout;
  logic         t_full, t_empty;
  logic [CW-1:0] t_count;
  logic [CW:0]  in_flight;

  // The tag FIFO occupancy is the count of outstanding (non-dropped) requests.
  assign in_flight        = {1'b0, q_count} + {1'b0, t_count};
  assign imem.imem_req_o  = (rst_i != RstEnable) && !jump_flag_i && (in_flight < QLIM);
  assign imem.imem_addr_o = pc;
  assign grant            = imem.imem_req_o && imem.imem_gnt_i;
  assign resp_keep        = imem.imem_rvalid_i && (drop_cnt == '0) && !jump_flag_i;

`ifdef FETCH_BYPASS_EN
  assign byp = resp_keep && q_empty && (rst_i != RstEnable);
`else
  assign byp = 1'b0;
`endif

  assign q_push = resp_keep && !(byp && id_ready_i);
  assign q_pop  = !q_empty && id_ready_i;
  assign q_din  = '{pc: tag_dout, inst: imem.imem_rdata_i};

  fetch_fifo #(.WIDTH(InstAddrBus), .DEPTH(QDEPTH)) u_tag_fifo (
    .clk   (clk_i),
    .rst   (rst_i),
    .flush (jump_flag_i),
    .push  (grant),
    .din   (pc),
    .pop   (resp_keep),
    .dout  (tag_dout),
    .full  (t_full),
    .empty (t_empty),
    .count (t_count)
  );

  fetch_fifo #(.WIDTH($bits(fetch_entry_t)), .DEPTH(QDEPTH)) u_inst_q (
    .clk   (clk_i),
    .rst   (rst_i),
    .flush (jump_flag_i),
    .push  (q_push),
    .din   (q_din),
    .pop   (q_pop),
    .dout  (q_dout),
    .full  (q_full),
    .empty (q_empty),
    .count (q_count)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i == RstEnable) begin
      pc       <= RESET_PC;
      drop_cnt <= '0;
    end else if (jump_flag_i) begin
      pc       <= {jump_addr_i[InstAddrBus-1:2], 2'b00};
      // Every response still in flight (pending drops plus tagged requests)
      // must be discarded; one arriving now is already accounted for.
      drop_cnt <= drop_cnt + DW'(t_count) - DW'(imem.imem_rvalid_i);
    end else begin
      if (grant) pc <= pc + PC_INC;
      if (imem.imem_rvalid_i && (drop_cnt != '0)) drop_cnt <= drop_cnt - 1'b1;
    end
  end

  always_comb begin
    inst_valid_o = 1'b0;
    inst_o       = INST_NOP;
    inst_addr_o  = '0;
    if (!q_empty) begin
      inst_valid_o = 1'b1;
      inst_o       = q_dout.inst;
      inst_addr_o  = q_dout.pc;
    end else if (byp) begin
      inst_valid_o = 1'b1;
      inst_o       = imem.imem_rdata_i;
      inst_addr_o  = tag_dout;
    end
  end

  a_no_orphan_resp: assert property (@(posedge clk_i) disable iff (rst_i)
    resp_keep |-> !t_empty);
  a_tag_room: assert property (@(posedge clk_i) disable iff (rst_i)
    grant |-> (!t_full && !(q_full && t_count != '0)));

endmodule

// File: tb/tb_pc_fetch.sv
// Directed and randomised self-checking bench for pc_fetch with a
// behavioural in-order instruction memory.
module tb_pc_fetch;
  import pc_fetch_pkg::*;

  localparam addr_t RST_PC = 32'h0000_0000;
`ifdef FETCH_BYPASS_EN
  localparam int FIRST_LAT = 1;
`else
  localparam int FIRST_LAT = 2;
`endif

  typedef struct { addr_t addr; int due; } resp_t;
  typedef struct { addr_t addr; inst_t inst; } acc_t;

  logic  clk = 1'b0;
  logic  rst = 1'b1;
  logic  jump_flag = 1'b0;
  addr_t jump_addr = '0;
  logic  id_ready = 1'b1;
  logic  inst_valid;
  inst_t inst;
  addr_t inst_addr;

  pc_fetch_if imem();

  pc_fetch #(.RESET_PC(RST_PC), .QDEPTH(2)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .imem         (imem),
    .jump_flag_i  (jump_flag),
    .jump_addr_i  (jump_addr),
    .inst_valid_o (inst_valid),
    .inst_o       (inst),
    .inst_addr_o  (inst_addr),
    .id_ready_i   (id_ready)
  );

  always #5 clk = ~clk;

  int    checks = 0;
  int    failures = 0;
  int    cyc = 0;
  int    lat_min = 1, lat_max = 1, gnt_max = 0, gnt_wait = 0;
  resp_t pend[$];
  acc_t  acc_log[$];
  addr_t grant_log[$];
  int    grant_cyc[$];
  logic  last_rv, last_pop, last_valid;

  function automatic inst_t mem_word(input addr_t a);
    return {~a[15:0], a[15:0]} ^ 32'h5A00_0000;
  endfunction

  // One clock cycle, entered and left at a negedge: drive memory, sample, clock.
  task automatic tick();
    logic  g, rq;
    addr_t ga;
    if (!rst && pend.size() > 0 && pend[0].due <= cyc) begin
      imem.imem_rvalid_i = 1'b1;
      imem.imem_rdata_i  = mem_word(pend[0].addr);
    end else begin
      imem.imem_rvalid_i = 1'b0;
      imem.imem_rdata_i  = 32'hDEAD_BEEF;
    end
    imem.imem_gnt_i = (gnt_wait == 0);
    #1;
    rq = imem.imem_req_o;
    g  = rq && imem.imem_gnt_i;
    ga = imem.imem_addr_o;
    last_rv    = imem.imem_rvalid_i;
    last_valid = inst_valid;
    last_pop   = inst_valid && id_ready;
    if (last_pop) acc_log.push_back('{inst_addr, inst});
    if (g) begin
      grant_log.push_back(ga);
      grant_cyc.push_back(cyc);
    end
    @(posedge clk);
    if (last_rv) void'(pend.pop_front());
    if (g) begin
      pend.push_back('{ga, cyc + int'($urandom_range(lat_max, lat_min))});
      gnt_wait = int'($urandom_range(gnt_max, 0));
    end else if (rq && gnt_wait > 0) begin
      gnt_wait--;
    end
    cyc++;
    @(negedge clk);
    imem.imem_rvalid_i = 1'b0;
    imem.imem_gnt_i    = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    jump_flag = 1'b0;
    id_ready = 1'b1;
    imem.imem_rvalid_i = 1'b0;
    imem.imem_gnt_i = 1'b0;
    pend.delete();
    gnt_wait = 0; gnt_max = 0; lat_min = 1; lat_max = 1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    cyc = 0;
    acc_log.delete(); grant_log.delete(); grant_cyc.delete();
  endtask

  task automatic test_reset();
    @(negedge clk); #1;
    checks++; if (imem.imem_req_o !== 1'b0) begin failures++; $display("FAIL rst_req got=%b exp=0", imem.imem_req_o); end
    checks++; if (inst_valid !== 1'b0) begin failures++; $display("FAIL rst_valid got=%b exp=0", inst_valid); end
    checks++; if (inst !== INST_NOP) begin failures++; $display("FAIL rst_inst got=%h exp=%h", inst, INST_NOP); end
    checks++; if (inst_addr !== 32'h0) begin failures++; $display("FAIL rst_inst_addr got=%h exp=0", inst_addr); end
    checks++; if (imem.imem_addr_o !== RST_PC) begin failures++; $display("FAIL rst_pc got=%h exp=%h", imem.imem_addr_o, RST_PC); end
  endtask

  task automatic test_release();
    int first_valid = -1;
    do_reset();
    for (int i = 0; i < 12; i++) begin
      int c = cyc;
      tick();
      if (last_valid && first_valid < 0) first_valid = c;
    end
    checks++; if (grant_log.size() < 3) begin failures++; $display("FAIL rel_grants got=%0d exp>=3", grant_log.size()); end
    else begin
      checks++; if (grant_log[0] !== 32'h0 || grant_log[1] !== 32'h4 || grant_log[2] !== 32'h8) begin
        failures++; $display("FAIL rel_addrs got=%h,%h,%h exp=0,4,8", grant_log[0], grant_log[1], grant_log[2]); end
      checks++; if (grant_cyc[0] !== 0 || grant_cyc[1] !== 1) begin
        failures++; $display("FAIL rel_grant_cyc got=%0d,%0d exp=0,1", grant_cyc[0], grant_cyc[1]); end
      checks++; if (first_valid - grant_cyc[0] !== FIRST_LAT) begin
        failures++; $display("FAIL rel_latency got=%0d exp=%0d", first_valid - grant_cyc[0], FIRST_LAT); end
    end
    checks++; if (acc_log.size() < 1 || acc_log[0].addr !== 32'h0 || acc_log[0].inst !== mem_word(32'h0)) begin
      failures++; $display("FAIL rel_first_inst got_n=%0d exp first addr 0", acc_log.size()); end
  endtask

  task automatic test_stall();
    inst_t prev = INST_NOP;
    int    viol = 0;
    do_reset();
    id_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick(); #1;
      if (i >= 2 && inst !== prev) viol++;
      prev = inst;
    end
    checks++; if (grant_log.size() !== 2) begin failures++; $display("FAIL stall_grants got=%0d exp=2", grant_log.size()); end
    checks++; if (imem.imem_req_o !== 1'b0) begin failures++; $display("FAIL stall_req got=%b exp=0", imem.imem_req_o); end
    checks++; if (inst_valid !== 1'b1 || inst_addr !== 32'h0) begin
      failures++; $display("FAIL stall_head got=%b/%h exp=1/0", inst_valid, inst_addr); end
    checks++; if (inst !== mem_word(32'h0) || viol !== 0) begin
      failures++; $display("FAIL stall_stable got=%h viol=%0d exp=%h viol=0", inst, viol, mem_word(32'h0)); end
    id_ready = 1'b1;
    for (int i = 0; i < 20 && acc_log.size() < 2; i++) tick();
    checks++; if (acc_log.size() < 2) begin failures++; $display("FAIL stall_release got=%0d exp>=2", acc_log.size()); end
    else begin
      checks++; if (acc_log[0].addr !== 32'h0 || acc_log[1].addr !== 32'h4 || acc_log[1].inst !== mem_word(32'h4)) begin
        failures++; $display("FAIL stall_order got=%h,%h exp=0,4", acc_log[0].addr, acc_log[1].addr); end
    end
  endtask

  task automatic test_redirect();
    do_reset();
    lat_min = 4; lat_max = 4;
    tick(); tick();
    checks++; if (grant_log.size() !== 2) begin failures++; $display("FAIL redir_outst got=%0d exp=2", grant_log.size()); end
    jump_flag = 1'b1; jump_addr = 32'h100; #1;
    checks++; if (imem.imem_req_o !== 1'b0) begin failures++; $display("FAIL redir_req_low got=%b exp=0", imem.imem_req_o); end
    tick();
    jump_flag = 1'b0; #1;
    checks++; if (imem.imem_req_o !== 1'b1 || imem.imem_addr_o !== 32'h100) begin
      failures++; $display("FAIL redir_resume got=%b/%h exp=1/100", imem.imem_req_o, imem.imem_addr_o); end
    for (int i = 0; i < 20 && acc_log.size() < 1; i++) tick();
    checks++; if (acc_log.size() < 1 || acc_log[0].addr !== 32'h100 || acc_log[0].inst !== mem_word(32'h100)) begin
      failures++; $display("FAIL redir_first got_n=%0d exp first addr 100", acc_log.size()); end
  endtask

  task automatic test_jump_rvalid_pop();
    do_reset();
    lat_min = 2; lat_max = 2;
    id_ready = 1'b0;
    tick(); tick(); tick();
    id_ready = 1'b1;
    jump_flag = 1'b1; jump_addr = 32'h200;
    tick();
    checks++; if (last_rv !== 1'b1 || last_pop !== 1'b1) begin
      failures++; $display("FAIL jrp_setup got rv=%b pop=%b exp=1/1", last_rv, last_pop); end
    checks++; if (acc_log.size() !== 1 || acc_log[0].addr !== 32'h0) begin
      failures++; $display("FAIL jrp_popped got_n=%0d exp one at addr 0", acc_log.size()); end
    jump_flag = 1'b0; #1;
    checks++; if (inst_valid !== 1'b0 || inst !== INST_NOP || inst_addr !== 32'h0) begin
      failures++; $display("FAIL jrp_flushed got=%b/%h/%h exp=0/%h/0", inst_valid, inst, inst_addr, INST_NOP); end
    for (int i = 0; i < 20 && acc_log.size() < 2; i++) tick();
    checks++; if (acc_log.size() < 2 || acc_log[1].addr !== 32'h200) begin
      failures++; $display("FAIL jrp_next got_n=%0d exp next addr 200", acc_log.size()); end
  endtask

  task automatic test_random();
    addr_t exp_next = RST_PC;
    int    n_acc = 0;
    do_reset();
    lat_min = 1; lat_max = 5; gnt_max = 5;
    for (int i = 0; i < 800; i++) begin
      logic jumped;
      id_ready = ($urandom_range(9, 0) < 7);
      jumped = ($urandom_range(39, 0) == 0);
      if (jumped) begin
        jump_flag = 1'b1;
        jump_addr = {20'h0, 10'($urandom_range(1023, 0)), 2'b00};
      end
      tick();
      if (last_pop) begin
        acc_t a = acc_log[acc_log.size()-1];
        checks++; if (a.addr !== exp_next) begin failures++; $display("FAIL rnd_addr cyc=%0d got=%h exp=%h", cyc, a.addr, exp_next); end
        checks++; if (a.inst !== mem_word(a.addr)) begin failures++; $display("FAIL rnd_inst cyc=%0d got=%h exp=%h", cyc, a.inst, mem_word(a.addr)); end
        exp_next = a.addr + 32'd4;
        n_acc++;
      end
      if (jumped) exp_next = jump_addr;
      jump_flag = 1'b0;
    end
    checks++; if (n_acc < 50) begin failures++; $display("FAIL rnd_progress got=%0d exp>=50", n_acc); end
  endtask

  task automatic test_reset_inflight();
    do_reset();
    lat_min = 4; lat_max = 4;
    tick(); tick();
    #2 rst = 1'b1;
    #1;
    checks++; if (imem.imem_req_o !== 1'b0 || imem.imem_addr_o !== RST_PC) begin
      failures++; $display("FAIL rif_bus got=%b/%h exp=0/%h", imem.imem_req_o, imem.imem_addr_o, RST_PC); end
    checks++; if (inst_valid !== 1'b0 || inst !== INST_NOP || inst_addr !== 32'h0) begin
      failures++; $display("FAIL rif_outs got=%b/%h/%h exp=0/%h/0", inst_valid, inst, inst_addr, INST_NOP); end
    pend.delete();
    gnt_wait = 0; lat_min = 1; lat_max = 1;
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    cyc = 0;
    acc_log.delete(); grant_log.delete(); grant_cyc.delete();
    for (int i = 0; i < 15 && acc_log.size() < 2; i++) tick();
    checks++; if (grant_log.size() < 1 || grant_log[0] !== RST_PC || grant_cyc[0] !== 0) begin
      failures++; $display("FAIL rif_first_req got_n=%0d exp addr %h at cycle 0", grant_log.size(), RST_PC); end
    checks++; if (acc_log.size() < 2 || acc_log[0].addr !== RST_PC || acc_log[1].addr !== RST_PC + 32'd4) begin
      failures++; $display("FAIL rif_refetch got_n=%0d exp %h then +4", acc_log.size(), RST_PC); end
  endtask

  initial begin
    imem.imem_gnt_i = 1'b0;
    imem.imem_rvalid_i = 1'b0;
    imem.imem_rdata_i = '0;
    test_reset();
    test_release();
    test_stall();
    test_redirect();
    test_jump_rvalid_pop();
    test_random();
    test_reset_inflight();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
